// File: rtl/video_timing_gen_multi.sv
// video_timing_gen_multi: two-mode video timing generator with line scaling and strobes.
// Mode and scale are latched only at the frame boundary so a frame is never torn.
module video_timing_gen_multi #(
    parameter int CNT_W    = 11,
    parameter int M0_HVIS  = 640,
    parameter int M0_HFP   = 16,
    parameter int M0_HSYNC = 96,
    parameter int M0_HBP   = 48,
    parameter int M0_VVIS  = 400,
    parameter int M0_VFP   = 12,
    parameter int M0_VSYNC = 2,
    parameter int M0_VBP   = 35,
    parameter bit M0_HPOL  = 1'b0,
    parameter bit M0_VPOL  = 1'b1,
    parameter int M1_HVIS  = 640,
    parameter int M1_HFP   = 16,
    parameter int M1_HSYNC = 96,
    parameter int M1_HBP   = 48,
    parameter int M1_VVIS  = 480,
    parameter int M1_VFP   = 10,
    parameter int M1_VSYNC = 2,
    parameter int M1_VBP   = 33,
    parameter bit M1_HPOL  = 1'b0,
    parameter bit M1_VPOL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_sel,
    input  logic [1:0]       scale_sel,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             hsync,
    output logic             vsync,
    output logic             video_active,
    output logic             line_start,
    output logic             frame_start,
    output logic             vblank_start,
    output logic [CNT_W-1:0] row_index,
    output logic [1:0]       row_phase,
    output logic             active_mode
);
    localparam logic [CNT_W-1:0] M0_HV  = CNT_W'(M0_HVIS);
    localparam logic [CNT_W-1:0] M0_HSS = CNT_W'(M0_HVIS + M0_HFP);
    localparam logic [CNT_W-1:0] M0_HSE = CNT_W'(M0_HVIS + M0_HFP + M0_HSYNC);
    localparam logic [CNT_W-1:0] M0_HT1 = CNT_W'(M0_HVIS + M0_HFP + M0_HSYNC + M0_HBP - 1);
    localparam logic [CNT_W-1:0] M0_VV  = CNT_W'(M0_VVIS);
    localparam logic [CNT_W-1:0] M0_VSS = CNT_W'(M0_VVIS + M0_VFP);
    localparam logic [CNT_W-1:0] M0_VSE = CNT_W'(M0_VVIS + M0_VFP + M0_VSYNC);
    localparam logic [CNT_W-1:0] M0_VT1 = CNT_W'(M0_VVIS + M0_VFP + M0_VSYNC + M0_VBP - 1);
    localparam logic [CNT_W-1:0] M1_HV  = CNT_W'(M1_HVIS);
    localparam logic [CNT_W-1:0] M1_HSS = CNT_W'(M1_HVIS + M1_HFP);
    localparam logic [CNT_W-1:0] M1_HSE = CNT_W'(M1_HVIS + M1_HFP + M1_HSYNC);
    localparam logic [CNT_W-1:0] M1_HT1 = CNT_W'(M1_HVIS + M1_HFP + M1_HSYNC + M1_HBP - 1);
    localparam logic [CNT_W-1:0] M1_VV  = CNT_W'(M1_VVIS);
    localparam logic [CNT_W-1:0] M1_VSS = CNT_W'(M1_VVIS + M1_VFP);
    localparam logic [CNT_W-1:0] M1_VSE = CNT_W'(M1_VVIS + M1_VFP + M1_VSYNC);
    localparam logic [CNT_W-1:0] M1_VT1 = CNT_W'(M1_VVIS + M1_VFP + M1_VSYNC + M1_VBP - 1);

    logic [CNT_W-1:0] hc, vc, hvis, hss, hse, ht1, vvis, vss, vse, vt1;
    logic             mode_r, hpol, vpol, h_wrap, v_wrap, hs_on, vs_on;
    logic [1:0]       scale_r, shift, mask;

    always_comb begin
        hvis   = mode_r ? M1_HV  : M0_HV;
        hss    = mode_r ? M1_HSS : M0_HSS;
        hse    = mode_r ? M1_HSE : M0_HSE;
        ht1    = mode_r ? M1_HT1 : M0_HT1;
        vvis   = mode_r ? M1_VV  : M0_VV;
        vss    = mode_r ? M1_VSS : M0_VSS;
        vse    = mode_r ? M1_VSE : M0_VSE;
        vt1    = mode_r ? M1_VT1 : M0_VT1;
        hpol   = mode_r ? M1_HPOL : M0_HPOL;
        vpol   = mode_r ? M1_VPOL : M0_VPOL;
        h_wrap = hc == ht1;
        v_wrap = vc == vt1;
        hs_on  = hc >= hss && hc < hse;
        vs_on  = vc >= vss && vc < vse;
        // scale 3 aliases scale 2 (4x)
        shift  = scale_r[1] ? 2'd2 : {1'b0, scale_r[0]};
        mask   = scale_r[1] ? 2'd3 : {1'b0, scale_r[0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hc           <= '0;
            vc           <= '0;
            mode_r       <= mode_sel;
            scale_r      <= scale_sel;
            h_count      <= '0;
            v_count      <= '0;
            hsync        <= ~(mode_sel ? M1_HPOL : M0_HPOL);
            vsync        <= ~(mode_sel ? M1_VPOL : M0_VPOL);
            video_active <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            row_index    <= '0;
            row_phase    <= 2'd0;
            active_mode  <= mode_sel;
        end else begin
            hc <= h_wrap ? '0 : hc + 1'b1;
            if (h_wrap)
                vc <= v_wrap ? '0 : vc + 1'b1;
            if (h_wrap && v_wrap) begin
                mode_r  <= mode_sel;
                scale_r <= scale_sel;
            end
            h_count      <= hc;
            v_count      <= vc;
            hsync        <= hs_on ? hpol : ~hpol;
            vsync        <= vs_on ? vpol : ~vpol;
            video_active <= hc < hvis && vc < vvis;
            line_start   <= hc == '0;
            frame_start  <= hc == '0 && vc == '0;
            vblank_start <= hc == '0 && vc == vvis;
            row_index    <= vc >> shift;
            row_phase    <= vc[1:0] & mask;
            active_mode  <= mode_r;
        end
    end
endmodule

// File: tb/tb_video_timing_gen_multi.sv
// tb_video_timing_gen_multi: directed bench using shrunken timings so whole frames fit in a short run.
// Mode 0: 16x12 (hsync 10..12 low, vsync 8..9 high); mode 1: 20x15 (hsync 13..16 low, vsync 10..11 low).
module tb_video_timing_gen_multi;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode_sel = 1'b0;
    logic [1:0]  scale_sel = 2'd0;
    logic [10:0] h_count, v_count, row_index;
    logic        hsync, vsync, video_active, line_start, frame_start, vblank_start, active_mode;
    logic [1:0]  row_phase;
    logic [41:0] obs;

    int tests = 0;
    int fails = 0;
    int ch, cv, dh, dv;
    bit cm, dm, drst;
    logic [1:0] cs, ds;
    int r_bad, r_ls, r_fs, r_vb, r_hs_lo, r_vs_hi, r_va, r_am1, r_hs_ed, r_vs_ed, r_ls_gap, r_fs_gap;
    logic [41:0] r_obs, r_exp;

    video_timing_gen_multi #(
        .CNT_W(11),
        .M0_HVIS(8), .M0_HFP(2), .M0_HSYNC(3), .M0_HBP(3),
        .M0_VVIS(6), .M0_VFP(2), .M0_VSYNC(2), .M0_VBP(2),
        .M0_HPOL(1'b0), .M0_VPOL(1'b1),
        .M1_HVIS(10), .M1_HFP(3), .M1_HSYNC(4), .M1_HBP(3),
        .M1_VVIS(8), .M1_VFP(2), .M1_VSYNC(2), .M1_VBP(3),
        .M1_HPOL(1'b0), .M1_VPOL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .mode_sel(mode_sel), .scale_sel(scale_sel),
        .h_count(h_count), .v_count(v_count), .hsync(hsync), .vsync(vsync),
        .video_active(video_active), .line_start(line_start), .frame_start(frame_start),
        .vblank_start(vblank_start), .row_index(row_index), .row_phase(row_phase),
        .active_mode(active_mode)
    );

    always #5 clk = ~clk;

    assign obs = {h_count, v_count, hsync, vsync, video_active, line_start, frame_start,
                  vblank_start, row_index, row_phase, active_mode};

    // reference model: (dh, dv, dm, ds) is what the outputs should show after the latest edge
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            drst = 1; dh = 0; dv = 0; dm = mode_sel; ds = scale_sel;
            ch = 0; cv = 0; cm = mode_sel; cs = scale_sel;
        end else begin
            drst = 0; dh = ch; dv = cv; dm = cm; ds = cs;
            if (ch == (cm ? 19 : 15)) begin
                ch = 0;
                if (cv == (cm ? 14 : 11)) begin
                    cv = 0; cm = mode_sel; cs = scale_sel;
                end else cv++;
            end else ch++;
        end
        #1;
    endtask

    function automatic logic [41:0] expv();
        int hv, hss, hse, vv, vss, vse, sh;
        bit hp, vp;
        hv = dm ? 10 : 8;  hss = dm ? 13 : 10; hse = dm ? 17 : 13;
        vv = dm ? 8 : 6;   vss = dm ? 10 : 8;  vse = dm ? 12 : 10;
        hp = 1'b0;         vp = dm ? 1'b0 : 1'b1;
        sh = ds == 2'd0 ? 0 : ds == 2'd1 ? 1 : 2;
        if (drst) return {22'd0, ~hp, ~vp, 4'd0, 11'd0, 2'd0, dm};
        return {11'(dh), 11'(dv), (dh >= hss && dh < hse) ? hp : ~hp,
                (dv >= vss && dv < vse) ? vp : ~vp, dh < hv && dv < vv, dh == 0,
                dh == 0 && dv == 0, dh == 0 && dv == vv, 11'(dv >> sh),
                2'(dv & ((1 << sh) - 1)), dm};
    endfunction

    task automatic run_cycles(input int n);
        int lls, lfs;
        logic ph, pv;
        r_bad = 0; r_ls = 0; r_fs = 0; r_vb = 0; r_hs_lo = 0; r_vs_hi = 0; r_va = 0;
        r_am1 = 0; r_hs_ed = 0; r_vs_ed = 0; r_ls_gap = -1; r_fs_gap = -1;
        lls = -1; lfs = -1; ph = hsync; pv = vsync;
        for (int i = 0; i < n; i++) begin
            tick();
            if (obs !== expv()) begin
                if (r_bad == 0) begin r_obs = obs; r_exp = expv(); end
                r_bad++;
            end
            if (line_start) begin
                r_ls++;
                if (lls >= 0) r_ls_gap = r_ls_gap == -1 ? i - lls : (r_ls_gap == i - lls ? r_ls_gap : -2);
                lls = i;
            end
            if (frame_start) begin
                r_fs++;
                if (lfs >= 0) r_fs_gap = r_fs_gap == -1 ? i - lfs : (r_fs_gap == i - lfs ? r_fs_gap : -2);
                lfs = i;
            end
            r_vb += int'(vblank_start);
            r_hs_lo += int'(!hsync);
            r_vs_hi += int'(vsync);
            r_va += int'(video_active);
            r_am1 += int'(active_mode);
            r_hs_ed += int'(hsync != ph);
            r_vs_ed += int'(vsync != pv);
            ph = hsync; pv = vsync;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mode_sel = 1'b0; scale_sel = 2'd0;
        run_cycles(3);
        tests++; if ({h_count, v_count} !== 22'd0) begin fails++; $display("FAIL rst_counts: got h=%0d v=%0d want 0 0", h_count, v_count); end
        tests++; if ({hsync, vsync} !== 2'b10) begin fails++; $display("FAIL rst_sync: got hs=%b vs=%b want 1 0", hsync, vsync); end
        tests++; if ({video_active, line_start, frame_start, active_mode} !== 4'b0000) begin fails++; $display("FAIL rst_flags: got %b want 0000", {video_active, line_start, frame_start, active_mode}); end
        tests++; if (r_bad !== 0) begin fails++; $display("FAIL rst_vectors: %0d bad, got %h want %h", r_bad, r_obs, r_exp); end
        rst = 1'b0;
        run_cycles(1);
        tests++; if ({frame_start, line_start, video_active} !== 3'b111 || {h_count, v_count} !== 22'd0) begin fails++; $display("FAIL rst_first: got fs/ls/va=%b h=%0d v=%0d want 111 0 0", {frame_start, line_start, video_active}, h_count, v_count); end
    endtask

    task automatic test_mode0_frames();
        run_cycles(384);
        tests++; if (r_bad !== 0) begin fails++; $display("FAIL m0_vectors: %0d bad, got %h want %h", r_bad, r_obs, r_exp); end
        tests++; if (r_ls_gap !== 16 || r_ls !== 24) begin fails++; $display("FAIL m0_line_period: got gap=%0d n=%0d want 16 24", r_ls_gap, r_ls); end
        tests++; if (r_fs_gap !== 192 || r_fs !== 2) begin fails++; $display("FAIL m0_frame_period: got gap=%0d n=%0d want 192 2", r_fs_gap, r_fs); end
        tests++; if (r_hs_lo !== 72) begin fails++; $display("FAIL m0_hsync_low: got %0d want 72", r_hs_lo); end
        tests++; if (r_vs_hi !== 64) begin fails++; $display("FAIL m0_vsync_high: got %0d want 64", r_vs_hi); end
        tests++; if (r_va !== 96 || r_vb !== 2) begin fails++; $display("FAIL m0_active_vblank: got va=%0d vb=%0d want 96 2", r_va, r_vb); end
    endtask

    task automatic test_mode_switch();
        run_cycles(48);
        mode_sel = 1'b1;
        run_cycles(143);
        tests++; if (r_am1 !== 0 || r_bad !== 0 || {h_count, v_count} !== {11'd15, 11'd11}) begin fails++; $display("FAIL sw_hold: got am1=%0d bad=%0d h=%0d v=%0d want 0 0 15 11", r_am1, r_bad, h_count, v_count); end
        run_cycles(1);
        tests++; if ({active_mode, frame_start} !== 2'b11) begin fails++; $display("FAIL sw_boundary: got am/fs=%b want 11", {active_mode, frame_start}); end
        run_cycles(300);
        tests++; if (r_bad !== 0) begin fails++; $display("FAIL m1_vectors: %0d bad, got %h want %h", r_bad, r_obs, r_exp); end
        tests++; if (r_ls !== 15 || r_fs !== 1 || r_ls_gap !== 20) begin fails++; $display("FAIL m1_lines: got ls=%0d fs=%0d gap=%0d want 15 1 20", r_ls, r_fs, r_ls_gap); end
        tests++; if (300 - r_vs_hi !== 40 || r_hs_lo !== 60) begin fails++; $display("FAIL m1_sync: got vs_lo=%0d hs_lo=%0d want 40 60", 300 - r_vs_hi, r_hs_lo); end
        tests++; if (r_va !== 80 || r_vb !== 1 || r_am1 !== 300) begin fails++; $display("FAIL m1_active: got va=%0d vb=%0d am1=%0d want 80 1 300", r_va, r_vb, r_am1); end
    endtask

    task automatic test_scale();
        int sbad;
        scale_sel = 2'd1;
        run_cycles(140); sbad = r_bad;
        tests++; if ({row_index, row_phase} !== {11'd7, 2'd0}) begin fails++; $display("FAIL sc_not_yet: got ri=%0d rp=%0d want 7 0", row_index, row_phase); end
        run_cycles(160); sbad += r_bad;
        run_cycles(140); sbad += r_bad;
        tests++; if ({row_index, row_phase} !== {11'd3, 2'd1} || v_count !== 11'd7) begin fails++; $display("FAIL sc_2x: got v=%0d ri=%0d rp=%0d want 7 3 1", v_count, row_index, row_phase); end
        scale_sel = 2'd3;
        run_cycles(160); sbad += r_bad;
        run_cycles(140); sbad += r_bad;
        tests++; if ({row_index, row_phase} !== {11'd1, 2'd3} || v_count !== 11'd7) begin fails++; $display("FAIL sc_4x: got v=%0d ri=%0d rp=%0d want 7 1 3", v_count, row_index, row_phase); end
        tests++; if (sbad !== 0) begin fails++; $display("FAIL sc_vectors: %0d bad, got %h want %h", sbad, r_obs, r_exp); end
    endtask

    task automatic test_mid_reset();
        mode_sel = 1'b0; scale_sel = 2'd0;
        run_cycles(65);
        tests++; if ({h_count, v_count, active_mode} !== {11'd5, 11'd10, 1'b1}) begin fails++; $display("FAIL mr_pre: got h=%0d v=%0d am=%b want 5 10 1", h_count, v_count, active_mode); end
        rst = 1'b1;
        run_cycles(1);
        tests++; if ({h_count, v_count, row_index, active_mode} !== 34'd0 || {hsync, vsync} !== 2'b10) begin fails++; $display("FAIL mr_clear: got h=%0d v=%0d am=%b hs=%b vs=%b want 0 0 0 1 0", h_count, v_count, active_mode, hsync, vsync); end
        rst = 1'b0;
        run_cycles(1);
        tests++; if ({frame_start, line_start} !== 2'b11 || {h_count, v_count} !== 22'd0) begin fails++; $display("FAIL mr_first: got fs/ls=%b h=%0d v=%0d want 11 0 0", {frame_start, line_start}, h_count, v_count); end
        run_cycles(384);
        tests++; if (r_fs_gap !== 192 || r_fs !== 2 || r_bad !== 0) begin fails++; $display("FAIL mr_period: got gap=%0d n=%0d bad=%0d want 192 2 0", r_fs_gap, r_fs, r_bad); end
    endtask

    task automatic test_noop_switch();
        mode_sel = 1'b0;
        run_cycles(576);
        tests++; if (r_fs !== 3 || r_fs_gap !== 192 || r_am1 !== 0) begin fails++; $display("FAIL noop_frames: got n=%0d gap=%0d am1=%0d want 3 192 0", r_fs, r_fs_gap, r_am1); end
        tests++; if (r_hs_ed !== 72 || r_vs_ed !== 6) begin fails++; $display("FAIL noop_edges: got hs=%0d vs=%0d want 72 6", r_hs_ed, r_vs_ed); end
        tests++; if (r_bad !== 0) begin fails++; $display("FAIL noop_vectors: %0d bad, got %h want %h", r_bad, r_obs, r_exp); end
    endtask

    initial begin
        test_reset();
        test_mode0_frames();
        test_mode_switch();
        test_scale();
        test_mid_reset();
        test_noop_switch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
